// File: rtl/hex_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with per-slot blanking and PWM brightness.
// Optional blink support is compiled in when HEX_SCAN_BLINK_EN is defined.
module hex_scan_driver #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 64,
   parameter int NUM_DIGITS   = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] hex0_in,
   input  logic [7:0] hex1_in,
   input  logic [7:0] hex2_in,
   input  logic [7:0] hex3_in,
   input  logic [7:0] hex4_in,
   input  logic [7:0] hex5_in,
   input  logic [3:0] brightness,
   input  logic       enable,
`ifdef HEX_SCAN_BLINK_EN
   input  logic [5:0] blink_mask,
   input  logic [1:0] blink_rate,
`endif
   output logic [7:0] seg_out,
   output logic [5:0] dig_out,
   output logic       frame_start
);

   localparam int ACTIVE = SCAN_DIV - BLANK_CYCLES;
   localparam int CW     = $clog2(SCAN_DIV);
   localparam int LW     = $clog2(SCAN_DIV * 16 + 1);

   typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_OFF} phase_t;

   function automatic logic [LW-1:0] on_len_of(input logic [3:0] b);
      logic [LW-1:0] prod;
      prod = LW'(ACTIVE) * LW'({1'b0, b} + 5'd1);
      return prod >> 4;
   endfunction

   function automatic phase_t phase_of(input logic [CW-1:0] c, input logic [LW-1:0] len);
      logic [LW:0] cx;
      logic [LW:0] on_end;
      phase_t      ph;
      cx     = (LW+1)'(c);
      on_end = (LW+1)'(BLANK_CYCLES) + (LW+1)'(len);
      if (cx < (LW+1)'(BLANK_CYCLES)) ph = PH_BLANK;
      else if (cx < on_end)           ph = PH_ON;
      else                            ph = PH_OFF;
      return ph;
   endfunction

   logic [CW-1:0]               cnt_p0, cnt_nxt;
   logic [2:0]                  idx_p0, idx_nxt;
   logic [LW-1:0]               on_len_p0, on_len_nxt;
   phase_t                      phase_p0, phase_nxt;
   logic [NUM_DIGITS-1:0][7:0]  shadow_p0;
   logic                        wrap, snap, hide;
   logic [7:0]                  seg_sel;

   always_comb begin
      wrap       = (cnt_p0 == CW'(SCAN_DIV - 1));
      snap       = (cnt_p0 == '0) && (idx_p0 == 3'd0);
      cnt_nxt    = wrap ? '0 : cnt_p0 + CW'(1);
      idx_nxt    = idx_p0;
      if (wrap) idx_nxt = (idx_p0 == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_p0 + 3'd1;
      on_len_nxt = snap ? on_len_of(brightness) : on_len_p0;
      phase_nxt  = phase_of(cnt_nxt, on_len_nxt);
      case (idx_p0)
         3'd0:    seg_sel = shadow_p0[0];
         3'd1:    seg_sel = shadow_p0[1];
         3'd2:    seg_sel = shadow_p0[2];
         3'd3:    seg_sel = shadow_p0[3];
         3'd4:    seg_sel = shadow_p0[4];
         3'd5:    seg_sel = shadow_p0[5];
         default: seg_sel = 8'hFF;
      endcase
   end

   // p0: slot counter, digit index, slot phase and frame snapshot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_p0    <= '0;
         idx_p0    <= 3'd0;
         on_len_p0 <= '0;
         phase_p0  <= phase_of('0, '0);
         shadow_p0 <= '1;
      end else begin
         cnt_p0    <= cnt_nxt;
         idx_p0    <= idx_nxt;
         on_len_p0 <= on_len_nxt;
         phase_p0  <= phase_nxt;
         if (snap) shadow_p0 <= {hex5_in, hex4_in, hex3_in, hex2_in, hex1_in, hex0_in};
      end
   end

`ifdef HEX_SCAN_BLINK_EN
   logic [6:0] frame_cnt_p0;
   logic [5:0] blink_mask_p0;
   logic       blink_p0;

   // Blink phase is latched with the snapshot so it is constant across a frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_p0  <= '0;
         blink_mask_p0 <= '0;
         blink_p0      <= 1'b0;
      end else if (snap) begin
         frame_cnt_p0  <= frame_cnt_p0 + 7'd1;
         blink_mask_p0 <= blink_mask;
         blink_p0      <= frame_cnt_p0[3'd3 + {1'b0, blink_rate}];
      end
   end

   assign hide = blink_p0 & blink_mask_p0[idx_p0];
`else
   assign hide = 1'b0;
`endif

   // p1: registered display outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_out     <= 8'hFF;
         dig_out     <= 6'h3F;
         frame_start <= 1'b0;
      end else begin
         frame_start <= snap;
         if (enable && (phase_p0 == PH_ON) && !hide) begin
            dig_out <= ~(6'b1 << idx_p0);
            seg_out <= seg_sel;
         end else begin
            dig_out <= 6'h3F;
            seg_out <= 8'hFF;
         end
      end
   end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with a 16-cycle slot and 2-cycle blanking (96-cycle frame).
module tb_hex_scan_driver;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] hex0_in, hex1_in, hex2_in, hex3_in, hex4_in, hex5_in;
   logic [3:0] brightness;
   logic       enable;
   logic [7:0] seg_out;
   logic [5:0] dig_out;
   logic       frame_start;
`ifdef HEX_SCAN_BLINK_EN
   logic [5:0] blink_mask;
   logic [1:0] blink_rate;
`endif

   int cyc    = 0;
   int vec    = 0;
   int miscmp = 0;

   logic [5:0] dig_tab [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
   logic [7:0] seg_tab [6] = '{8'hC0, 8'hF9, 8'hA4, 8'h79, 8'h99, 8'h92};

   hex_scan_driver #(.SCAN_DIV(16), .BLANK_CYCLES(2), .NUM_DIGITS(6)) dut (
      .clk(clk), .reset_n(reset_n),
      .hex0_in(hex0_in), .hex1_in(hex1_in), .hex2_in(hex2_in),
      .hex3_in(hex3_in), .hex4_in(hex4_in), .hex5_in(hex5_in),
      .brightness(brightness), .enable(enable),
`ifdef HEX_SCAN_BLINK_EN
      .blink_mask(blink_mask), .blink_rate(blink_rate),
`endif
      .seg_out(seg_out), .dig_out(dig_out), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges since the last reset release
   always @(posedge clk or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int n);
      int budget = 0;
      while (cyc < n && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      if (cyc != n) begin
         vec++; miscmp++;
         $display("FAIL wait_cyc reached %0d required %0d", cyc, n);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vec++;
         if ({frame_start, dig_out, seg_out} !== {1'b0, 6'h3F, 8'hFF}) begin
            miscmp++;
            $display("FAIL reset_hold fs/dig/seg got %b/%h/%h want 0/3f/ff", frame_start, dig_out, seg_out);
         end
      end
      reset_n = 1'b1;
      wait_cyc(20);
      vec++;
      if ({dig_out, seg_out} !== {6'h3D, 8'hF9}) begin
         miscmp++;
         $display("FAIL pre_reset_scan dig/seg got %h/%h want 3d/f9", dig_out, seg_out);
      end
      #1 reset_n = 1'b0;
      #1;
      vec++;
      if ({frame_start, dig_out, seg_out} !== {1'b0, 6'h3F, 8'hFF}) begin
         miscmp++;
         $display("FAIL async_reset fs/dig/seg got %b/%h/%h want 0/3f/ff", frame_start, dig_out, seg_out);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         vec++;
         if ({frame_start, dig_out, seg_out} !== {1'b0, 6'h3F, 8'hFF}) begin
            miscmp++;
            $display("FAIL reset_mid fs/dig/seg got %b/%h/%h want 0/3f/ff", frame_start, dig_out, seg_out);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      wait_cyc(1);
      vec++;
      if ({frame_start, dig_out, seg_out} !== {1'b1, 6'h3F, 8'hFF}) begin
         miscmp++;
         $display("FAIL release_c1 fs/dig/seg got %b/%h/%h want 1/3f/ff", frame_start, dig_out, seg_out);
      end
      wait_cyc(2);
      vec++;
      if ({frame_start, dig_out, seg_out} !== {1'b0, 6'h3F, 8'hFF}) begin
         miscmp++;
         $display("FAIL release_c2 fs/dig/seg got %b/%h/%h want 0/3f/ff", frame_start, dig_out, seg_out);
      end
   endtask

   task automatic test_full_brightness();
      for (int n = 3; n <= 32; n++) begin
         int p, c, i;
         logic [5:0] ed;
         logic [7:0] es;
         wait_cyc(n);
         p = n - 1; c = p % 16; i = p / 16;
         ed = (c >= 2) ? dig_tab[i] : 6'h3F;
         es = (c >= 2) ? seg_tab[i] : 8'hFF;
         vec++;
         if ({frame_start, dig_out, seg_out} !== {1'b0, ed, es}) begin
            miscmp++;
            $display("FAIL full_bright cyc=%0d fs/dig/seg got %b/%h/%h want 0/%h/%h",
                     n, frame_start, dig_out, seg_out, ed, es);
         end
      end
      brightness = 4'd7;
   endtask

   task automatic test_pwm();
      int on_cnt [6] = '{0, 0, 0, 0, 0, 0};
      for (int n = 97; n <= 192; n++) begin
         int p, c, i;
         logic on;
         logic [5:0] ed;
         logic [7:0] es;
         wait_cyc(n);
         p = n - 1; c = p % 16; i = (p / 16) % 6;
         on = (c >= 2) && (c <= 8);
         ed = on ? dig_tab[i] : 6'h3F;
         es = on ? seg_tab[i] : 8'hFF;
         if (dig_out != 6'h3F) on_cnt[i]++;
         vec++;
         if ({frame_start, dig_out, seg_out} !== {(n == 97), ed, es}) begin
            miscmp++;
            $display("FAIL pwm cyc=%0d fs/dig/seg got %b/%h/%h want %b/%h/%h",
                     n, frame_start, dig_out, seg_out, (n == 97), ed, es);
         end
      end
      for (int i = 0; i < 6; i++) begin
         vec++;
         if (on_cnt[i] != 7) begin
            miscmp++;
            $display("FAIL pwm_on_len digit=%0d got %0d cycles want 7", i, on_cnt[i]);
         end
      end
   endtask

   task automatic test_snapshot();
      wait_cyc(215);
      hex3_in = 8'h24;
      wait_cyc(245);
      vec++;
      if ({dig_out, seg_out} !== {6'h37, 8'h79}) begin
         miscmp++;
         $display("FAIL snap_same_frame dig/seg got %h/%h want 37/79", dig_out, seg_out);
      end
      wait_cyc(251);
      vec++;
      if ({dig_out, seg_out} !== {6'h3F, 8'hFF}) begin
         miscmp++;
         $display("FAIL snap_off_phase dig/seg got %h/%h want 3f/ff", dig_out, seg_out);
      end
      wait_cyc(341);
      vec++;
      if ({dig_out, seg_out} !== {6'h37, 8'h24}) begin
         miscmp++;
         $display("FAIL snap_next_frame dig/seg got %h/%h want 37/24", dig_out, seg_out);
      end
      seg_tab[3] = 8'h24;
      brightness = 4'd15;
   endtask

   task automatic test_enable();
      wait_cyc(420);
      vec++;
      if ({dig_out, seg_out} !== {6'h3B, 8'hA4}) begin
         miscmp++;
         $display("FAIL en_before dig/seg got %h/%h want 3b/a4", dig_out, seg_out);
      end
      enable = 1'b0;
      for (int n = 421; n <= 425; n++) begin
         wait_cyc(n);
         vec++;
         if ({dig_out, seg_out} !== {6'h3F, 8'hFF}) begin
            miscmp++;
            $display("FAIL en_low cyc=%0d dig/seg got %h/%h want 3f/ff", n, dig_out, seg_out);
         end
      end
      enable = 1'b1;
      wait_cyc(426);
      vec++;
      if ({dig_out, seg_out} !== {6'h3B, 8'hA4}) begin
         miscmp++;
         $display("FAIL en_resume dig/seg got %h/%h want 3b/a4", dig_out, seg_out);
      end
      wait_cyc(435);
      vec++;
      if ({dig_out, seg_out} !== {6'h37, 8'h24}) begin
         miscmp++;
         $display("FAIL en_next_digit dig/seg got %h/%h want 37/24", dig_out, seg_out);
      end
      wait_cyc(480);
      vec++;
      if (frame_start !== 1'b0) begin
         miscmp++;
         $display("FAIL en_fs_480 got %b want 0", frame_start);
      end
      wait_cyc(481);
      vec++;
      if (frame_start !== 1'b1) begin
         miscmp++;
         $display("FAIL en_fs_481 got %b want 1", frame_start);
      end
      wait_cyc(570);
      enable = 1'b0;
      for (int n = 571; n <= 580; n++) begin
         wait_cyc(n);
         vec++;
         if ({frame_start, dig_out} !== {(n == 577), 6'h3F}) begin
            miscmp++;
            $display("FAIL en_fs_disabled cyc=%0d fs/dig got %b/%h want %b/3f",
                     n, frame_start, dig_out, (n == 577));
         end
      end
      enable = 1'b1;
      wait_cyc(582);
      vec++;
      if ({dig_out, seg_out} !== {6'h3E, 8'hC0}) begin
         miscmp++;
         $display("FAIL en_reenable dig/seg got %h/%h want 3e/c0", dig_out, seg_out);
      end
   endtask

`ifdef HEX_SCAN_BLINK_EN
   task automatic test_blink();
      int         at [6] = '{709, 789, 805, 821, 1477, 1573};
      logic [5:0] wd [6] = '{6'h3B, 6'h3D, 6'h3F, 6'h37, 6'h3F, 6'h3B};
      logic [7:0] ws [6] = '{8'hA4, 8'hF9, 8'hFF, 8'h24, 8'hFF, 8'hA4};
      for (int k = 0; k < 6; k++) begin
         wait_cyc(at[k]);
         vec++;
         if ({dig_out, seg_out} !== {wd[k], ws[k]}) begin
            miscmp++;
            $display("FAIL blink cyc=%0d dig/seg got %h/%h want %h/%h",
                     at[k], dig_out, seg_out, wd[k], ws[k]);
         end
      end
   endtask
`endif

   initial begin
      reset_n    = 1'b0;
      hex0_in    = 8'hC0; hex1_in = 8'hF9; hex2_in = 8'hA4;
      hex3_in    = 8'h79; hex4_in = 8'h99; hex5_in = 8'h92;
      brightness = 4'd15;
      enable     = 1'b1;
`ifdef HEX_SCAN_BLINK_EN
      blink_mask = 6'b000100;
      blink_rate = 2'd0;
`endif
      test_reset();
      test_full_brightness();
      test_pwm();
      test_snapshot();
      test_enable();
`ifdef HEX_SCAN_BLINK_EN
      test_blink();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
